mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU memory handshake (MAR address, MEM_EN/MEM_RW request, MFC completion).
- Accepts one-cycle request strobes from the fetch/execute FSMs and performs a word read or write on an internal RAM after a fixed latency.
- Signals completion on active-low MFC and holds read data for capture into MDR.

Parameters:
- DATA_W, 16: word width, bits.
- ADDR_W, 8: address width, bits.
- DEPTH, 256: number of words implemented; must be 1..2^ADDR_W.
- LATENCY, 2: edges from accept edge to completion edge; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- MEM_EN  in  1  request strobe, sampled at posedge.
- MEM_RW  in  1  1 = read, 0 = write; sampled with MEM_EN.
- addr  in  ADDR_W  word address, driven from MAR.
- wdata  in  DATA_W  write data, driven from MDR.
- rdata  out  DATA_W  read data, registered.
- MFC  out  1  memory function complete, active-low; one-cycle low pulse.
- busy  out  1  high while a request is in flight (ACCESS or COMPLETE).

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, MFC=1, busy=0, rdata=0, counter=0.
  - RAM contents are not reset.
- States: IDLE, ACCESS, COMPLETE.
- IDLE:
  - MEM_EN=1 at edge E0 is the accept.
  - Latch addr, MEM_RW and wdata; counter=LATENCY-1; go to ACCESS.
  - busy=1 from E0.
- ACCESS:
  - Each edge with counter>0 decrements the counter.
  - At the edge where counter==0 (edge E0+LATENCY), perform the access, drive MFC=0, go to COMPLETE.
  - Read: rdata <= RAM[latched addr], registered at that edge.
  - Write: RAM[latched addr] <= latched wdata at that edge; rdata unchanged.
- COMPLETE:
  - Lasts exactly one cycle.
  - Next edge: MFC=1, busy=0, go to IDLE.
- Ordering:
  - The earliest new accept is the edge after leaving COMPLETE, i.e. back-to-back requests are spaced at least LATENCY+2 edges apart.
  - MEM_EN asserted in ACCESS or COMPLETE is ignored; no queueing.
- rdata holds its value until the next completed read. This guarantees MDR capture one or more cycles after MFC returns high.
- Address/data inputs are don't-care after the accept edge, since all are latched at E0.
- Out-of-range address (addr >= DEPTH):
  - Read returns 0; write is dropped.
  - MFC still pulses with normal timing.
- MEM_EN held high continuously: a new accept occurs every LATENCY+2 edges; each accept samples the current addr/MEM_RW/wdata.
- Reset mid-ACCESS: request aborted, no RAM write, MFC stays 1, rdata=0.
- Reset during COMPLETE: write already performed, MFC returns to 1 immediately, rdata cleared to 0.
- Widths: the counter holds LATENCY-1 in ceil(log2(LATENCY))+1 bits.

Optional Feature:
- Macro: MEM_RESPONDER_BUSY_ERR_EN.
- With the macro defined:
  - Adds output port err (1 bit, reset 0).
  - err is set sticky at any edge where MEM_EN=1 while busy=1, or where an out-of-range address is accepted.
  - err is cleared only by reset.
  - Access and MFC behaviour are unchanged.
- Without the macro: port err is absent; dropped requests and out-of-range accesses are silent.

Decomposition:
- Package mem_if_pkg holds:
  - state enum (IDLE, ACCESS, COMPLETE);
  - constants MEM_RW_READ=1'b1, MEM_RW_WRITE=1'b0;
  - MFC_ACTIVE=1'b0;
  - default DATA_W/ADDR_W values shared with the CPU datapath.
- Sub-module mem_array: single-port synchronous RAM, DEPTH x DATA_W, with write enable and registered read output. The responder FSM/counter instantiates it.

Test Plan:
- Reset then idle 10 cycles -> MFC=1, busy=0, rdata=0 throughout.
- LATENCY=2: write addr=0x10 wdata=0xBEEF (E0), then read addr=0x10 -> each MFC low exactly in the cycle after E0+2; rdata=0xBEEF after the read's completion edge, held for 5 further cycles.
- LATENCY=1: read accepted at E0 -> MFC low in the cycle after E0+1, high after E0+2, busy high from E0 to E0+2.
- Read request accepted, second MEM_EN pulse (write 0x1234 to 0x10) during ACCESS -> second ignored, RAM[0x10] unchanged; err=1 if MEM_RESPONDER_BUSY_ERR_EN is defined.
- DEPTH=200: write 0x5555 to addr=0xF0, then read 0xF0 -> MFC pulses normally, rdata=0x0000.
- Write 0xAAAA to addr=0x20 with reset asserted one edge after accept (LATENCY=3) -> MFC never low; subsequent read of 0x20 returns the prior content, not 0xAAAA.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU memory handshake: responder states and
// MEM_RW / MFC encodings, plus default bus widths used by the datapath.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } mem_state_t;

    localparam logic MEM_RW_READ  = 1'b1;
    localparam logic MEM_RW_WRITE = 1'b0;
    localparam logic MFC_ACTIVE   = 1'b0;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with registered read port.
// Addresses at or above DEPTH read as zero and drop writes.
module mem_array
    import mem_if_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;

    assign in_range = ({1'b0, addr} < DEPTH_L);

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= in_range ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a request strobe, performs the access after
// LATENCY edges and pulses MFC low. Optional err port: MEM_RESPONDER_BUSY_ERR_EN.
//   state    | meaning
//   IDLE     | waiting for MEM_EN
//   ACCESS   | request latched, counting down to the access edge
//   COMPLETE | access done, MFC low for this one cycle
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_EN,
    input  logic              MEM_RW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              MFC,
    output logic              busy
`ifdef MEM_RESPONDER_BUSY_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int              CNT_W    = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    mem_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_rw;
    logic              accept;
    logic              fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_EN) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    fire       = 1'b1;
                    state_next = COMPLETE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            COMPLETE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Request fields are captured at accept so the bus may change afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rw    <= MEM_RW_READ;
        end else if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_rw    <= MEM_RW;
        end
    end

    assign busy = (state != IDLE);
    assign MFC  = (state == COMPLETE) ? MFC_ACTIVE : ~MFC_ACTIVE;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (reset),
        .we    (fire && (lat_rw == MEM_RW_WRITE)),
        .re    (fire && (lat_rw == MEM_RW_READ)),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (rdata)
    );

`ifdef MEM_RESPONDER_BUSY_ERR_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic addr_in_range;
    assign addr_in_range = ({1'b0, addr} < DEPTH_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((MEM_EN && busy) || (accept && !addr_in_range)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances with different
// LATENCY/DEPTH, table vectors, corner sequences and a randomized phase.
module tb_mem_responder;
    import mem_if_pkg::*;

    localparam int LAT_T [3] = '{2, 1, 3};
    localparam int DEP_T [3] = '{256, 256, 200};

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  en, rw, mfc, busy;
    logic [7:0]  addr  [3];
    logic [15:0] wdata [3];
    logic [15:0] rdata [3];
`ifdef MEM_RESPONDER_BUSY_ERR_EN
    logic [2:0]  err;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DATA_W  (16),
            .ADDR_W  (8),
            .DEPTH   (DEP_T[g]),
            .LATENCY (LAT_T[g])
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .MEM_EN (en[g]),
            .MEM_RW (rw[g]),
            .addr   (addr[g]),
            .wdata  (wdata[g]),
            .rdata  (rdata[g]),
            .MFC    (mfc[g]),
            .busy   (busy[g])
`ifdef MEM_RESPONDER_BUSY_ERR_EN
            ,
            .err    (err[g])
`endif
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain word arrays, expected read register per instance.
    logic [15:0] mem_m [3][256];
    bit          wr_m  [3][256];
    logic [15:0] exp_rd [3];

    typedef struct {
        int          i;
        bit          r;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] e;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic req(input int i, input bit r, input logic [7:0] a, input logic [15:0] d,
                       output logic [15:0] got);
        int n;
        bit seen;
        @(negedge clk);
        en[i] = 1'b1; rw[i] = r; addr[i] = a; wdata[i] = d;
        @(posedge clk);
        #1;
        en[i] = 1'b0; rw[i] = 1'($urandom); addr[i] = 8'($urandom); wdata[i] = 16'($urandom);
        @(negedge clk);
        check("busy_after_accept", {31'b0, busy[i]}, 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mfc[i] == MFC_ACTIVE) seen = 1'b1;
        end
        check("mfc_latency", n, LAT_T[i]);
        check("busy_in_complete", {31'b0, busy[i]}, 32'd1);
        if (r) begin
            exp_rd[i] = (int'(a) < DEP_T[i]) ? mem_m[i][a] : 16'h0;
        end else if (int'(a) < DEP_T[i]) begin
            mem_m[i][a] = d;
            wr_m[i][a]  = 1'b1;
        end
        check("rdata_at_complete", {16'b0, rdata[i]}, {16'b0, exp_rd[i]});
        @(posedge clk);
        @(negedge clk);
        check("mfc_release", {31'b0, mfc[i]}, 32'd1);
        check("busy_release", {31'b0, busy[i]}, 32'd0);
        got = rdata[i];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        int n;

        reset = 1'b0;
        en = '0; rw = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; exp_rd[i] = '0;
            for (int k = 0; k < 256; k++) begin
                mem_m[i][k] = '0; wr_m[i][k] = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check("idle_mfc", {31'b0, mfc[i]}, 32'd1);
                check("idle_busy", {31'b0, busy[i]}, 32'd0);
                check("idle_rdata", {16'b0, rdata[i]}, 32'd0);
            end
        end

        tbl[0] = '{0, 1'b0, 8'h10, 16'hBEEF, 16'h0000};
        tbl[1] = '{0, 1'b1, 8'h10, 16'h0000, 16'hBEEF};
        tbl[2] = '{1, 1'b0, 8'h30, 16'h1111, 16'h0000};
        tbl[3] = '{1, 1'b1, 8'h30, 16'h0000, 16'h1111};
        tbl[4] = '{2, 1'b0, 8'h20, 16'h7777, 16'h0000};
        tbl[5] = '{2, 1'b0, 8'hF0, 16'h5555, 16'h0000};
        tbl[6] = '{2, 1'b1, 8'hF0, 16'h0000, 16'h0000};
        tbl[7] = '{2, 1'b1, 8'h20, 16'h0000, 16'h7777};

        for (int t = 0; t < 8; t++) begin
            req(tbl[t].i, tbl[t].r, tbl[t].a, tbl[t].d, got);
            check("table_rdata", {16'b0, got}, {16'b0, tbl[t].e});
            if (tbl[t].r) begin
                repeat (5) begin
                    @(negedge clk);
                    check("rdata_hold", {16'b0, rdata[tbl[t].i]}, {16'b0, tbl[t].e});
                end
            end
        end

`ifdef MEM_RESPONDER_BUSY_ERR_EN
        check("err_clean", {31'b0, err[0]}, 32'd0);
        check("err_oor", {31'b0, err[2]}, 32'd1);
`endif

        // Second strobe during ACCESS must be ignored.
        @(negedge clk);
        en[0] = 1'b1; rw[0] = MEM_RW_READ; addr[0] = 8'h10;
        @(posedge clk);
        #1 en[0] = 1'b0;
        @(negedge clk);
        en[0] = 1'b1; rw[0] = MEM_RW_WRITE; addr[0] = 8'h10; wdata[0] = 16'h1234;
        @(posedge clk);
        #1 en[0] = 1'b0;
        n = 1;
        while (mfc[0] !== MFC_ACTIVE && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("ignore_latency", n, 2);
        check("ignore_read", {16'b0, rdata[0]}, 32'h0000BEEF);
        @(posedge clk);
        @(negedge clk);
        check("ignore_no_extra_accept", {31'b0, busy[0]}, 32'd0);
        req(0, 1'b1, 8'h10, 16'h0, got);
        check("ignore_ram_unchanged", {16'b0, got}, 32'h0000BEEF);
`ifdef MEM_RESPONDER_BUSY_ERR_EN
        check("err_busy", {31'b0, err[0]}, 32'd1);
`endif

        // Reset one edge after accepting a write aborts it.
        @(negedge clk);
        en[2] = 1'b1; rw[2] = MEM_RW_WRITE; addr[2] = 8'h20; wdata[2] = 16'hAAAA;
        @(posedge clk);
        #1 en[2] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) exp_rd[i] = '0;
        repeat (6) begin
            @(negedge clk);
            check("rst_mfc", {31'b0, mfc[2]}, 32'd1);
            check("rst_busy", {31'b0, busy[2]}, 32'd0);
        end
        check("rst_rdata", {16'b0, rdata[2]}, 32'd0);
`ifdef MEM_RESPONDER_BUSY_ERR_EN
        check("rst_err", {29'b0, err}, 32'd0);
`endif
        reset = 1'b1;
        req(2, 1'b1, 8'h20, 16'h0, got);
        check("abort_prior_content", {16'b0, got}, 32'h00007777);

        for (int k = 0; k < 60; k++) begin
            int          i;
            bit          r;
            logic [7:0]  a;
            logic [15:0] d;
            i = $urandom_range(0, 2);
            a = (i == 2) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            r = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (r && int'(a) < DEP_T[i] && !wr_m[i][a]) r = 1'b0;
            req(i, r, a, d, got);
            check("rand_rdata", {16'b0, got}, {16'b0, exp_rd[i]});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
